// File: rtl/rv32i_pkg.sv
// Shared core package: architectural constants and skid buffer state encoding.
package rv32i_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } skid_state_e;

endpackage

// File: rtl/pipe_entry.sv
// Single pipeline storage entry: WIDTH-bit register with load enable
// and synchronous reset to RESET_VAL.
module pipe_entry #(
   parameter int                 WIDTH     = 32,
   parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_q <= RESET_VAL;
      end else if (i_load) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/skid_pipe_reg.sv
// Two-entry skid pipeline register with fully registered handshakes.
// Define SKID_PIPE_REG_PERF_EN to add the saturating stall_cnt output.
module skid_pipe_reg
   import rv32i_pkg::*;
#(
   parameter int               WIDTH     = XLEN,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int               CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
`ifdef SKID_PIPE_REG_PERF_EN
   ,
   output logic [CNT_W-1:0] stall_cnt
`endif
);

   if (WIDTH < 1 || CNT_W < 1) begin : g_param_chk
      $error("skid_pipe_reg: WIDTH and CNT_W must be >= 1");
   end

   skid_state_e      r_state;
   logic             r_out_valid;
   logic             r_in_ready;
   logic             w_in_xfer;
   logic             w_out_xfer;
   logic             w_clr;
   logic             w_main_ld;
   logic             w_skid_ld;
   logic [WIDTH-1:0] w_main_d;
   logic [WIDTH-1:0] w_main_q;
   logic [WIDTH-1:0] w_skid_q;

   assign w_in_xfer  = in_valid & r_in_ready;
   assign w_out_xfer = r_out_valid & out_ready;
   assign w_clr      = reset | flush;

   // Main refills from the skid entry only while draining out of SKID.
   assign w_main_ld = (w_in_xfer && (r_state == ST_EMPTY || w_out_xfer))
                    || (r_state == ST_SKID && w_out_xfer);
   assign w_main_d  = (r_state == ST_SKID) ? w_skid_q : in_data;
   assign w_skid_ld = (r_state == ST_FULL) && w_in_xfer && !w_out_xfer;

   pipe_entry #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
   ) u_main (
      .clk    (clk),
      .reset  (w_clr),
      .i_load (w_main_ld),
      .i_d    (w_main_d),
      .o_q    (w_main_q)
   );

   pipe_entry #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
   ) u_skid (
      .clk    (clk),
      .reset  (w_clr),
      .i_load (w_skid_ld),
      .i_d    (in_data),
      .o_q    (w_skid_q)
   );

   always_ff @(posedge clk) begin
      if (w_clr) begin
         r_state     <= ST_EMPTY;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_in_xfer) begin
                  r_state     <= ST_FULL;
                  r_out_valid <= 1'b1;
               end
            end
            ST_FULL: begin
               if (w_in_xfer && !w_out_xfer) begin
                  r_state    <= ST_SKID;
                  r_in_ready <= 1'b0;
               end else if (w_out_xfer && !w_in_xfer) begin
                  r_state     <= ST_EMPTY;
                  r_out_valid <= 1'b0;
               end
            end
            ST_SKID: begin
               if (w_out_xfer) begin
                  r_state    <= ST_FULL;
                  r_in_ready <= 1'b1;
               end
            end
            default: begin
               r_state     <= ST_EMPTY;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = w_main_q;

`ifdef SKID_PIPE_REG_PERF_EN
   logic [CNT_W-1:0] r_stall_cnt;

   // Flush is deliberately ignored: the count spans redirects.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cnt <= '0;
      end else if (r_out_valid && !out_ready && r_stall_cnt != '1) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_skid_pipe_reg.sv
// Bench for skid_pipe_reg: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_skid_pipe_reg;

   localparam int          W   = 32;
   localparam int          CW  = 4;
   localparam logic [31:0] RV  = 32'h0000_1000;
   localparam int          SAT = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  out_data;
`ifdef SKID_PIPE_REG_PERF_EN
   logic [CW-1:0] stall_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] m_q[$];
   logic [31:0] m_hold = RV;
   int          m_cnt  = 0;
   logic [31:0] got[$];

   skid_pipe_reg #(
      .WIDTH     (W),
      .RESET_VAL (RV),
      .CNT_W     (CW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef SKID_PIPE_REG_PERF_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
      end
   endtask

   // One clock: drive, advance the model at the edge, compare at negedge.
   task automatic cyc(input logic rst, input logic fl, input logic iv,
                      input logic [31:0] id, input logic ordy);
      logic m_ov;
      logic m_ir;
      reset     = rst;
      flush     = fl;
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      m_ov = (m_q.size() > 0);
      m_ir = (m_q.size() < 2);
      @(posedge clk);
      if (rst) begin
         m_cnt = 0;
      end else if (m_ov && !ordy && m_cnt < SAT) begin
         m_cnt = m_cnt + 1;
      end
      if (rst || fl) begin
         m_q.delete();
         m_hold = RV;
      end else begin
         if (m_ov && ordy) m_hold = m_q.pop_front();
         if (iv && m_ir) m_q.push_back(id);
      end
      @(negedge clk);
      chk("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
      chk("in_ready", 32'(in_ready), 32'(m_q.size() < 2));
      chk("out_data", out_data, (m_q.size() > 0) ? m_q[0] : m_hold);
`ifdef SKID_PIPE_REG_PERF_EN
      chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
`endif
   endtask

   initial begin
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      chk("rst_ov", 32'(out_valid), 32'd0);
      chk("rst_od", out_data, RV);

      // Streaming 0..7 with out_ready held high.
      for (int i = 0; i < 10; i++) begin
         cyc(0, 0, i < 8, 32'(i), 1);
         if (i == 0) chk("lat1", 32'(out_valid), 32'd1);
         if (out_valid) got.push_back(out_data);
      end
      chk("stream_n", 32'(got.size()), 32'd8);
      for (int i = 0; i < got.size(); i++) chk("stream_d", got[i], 32'(i));

      // Backpressure.
      cyc(0, 0, 1, 32'hA, 0);
      cyc(0, 0, 1, 32'hB, 0);
      chk("bp_hold", out_data, 32'hA);
      chk("bp_irdy", 32'(in_ready), 32'd0);
      cyc(0, 0, 0, 0, 0);
      chk("bp_stable", out_data, 32'hA);
      cyc(0, 0, 0, 0, 1);
      chk("bp_second", out_data, 32'hB);
      cyc(0, 0, 0, 0, 1);
      chk("bp_drain", 32'(out_valid), 32'd0);
      chk("bp_keep", out_data, 32'hB);

      // Flush while in SKID with a beat offered.
      cyc(0, 0, 1, 32'h1, 0);
      cyc(0, 0, 1, 32'h2, 0);
      cyc(0, 1, 1, 32'hC, 0);
      chk("fl_ov", 32'(out_valid), 32'd0);
      chk("fl_od", out_data, RV);
      chk("fl_ir", 32'(in_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 0, 1);
         chk("fl_no_c", 32'(out_valid), 32'd0);
      end

      // Reset with a beat in flight.
      cyc(0, 0, 1, 32'h5, 1);
      cyc(1, 0, 1, 32'h6, 1);
      chk("rs_ov", 32'(out_valid), 32'd0);
      chk("rs_od", out_data, RV);
      chk("rs_ir", 32'(in_ready), 32'd1);

`ifdef SKID_PIPE_REG_PERF_EN
      cyc(0, 0, 1, 32'h7, 0);
      for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0);
      chk("perf_sat", 32'(stall_cnt), 32'(SAT));
      cyc(0, 1, 0, 0, 0);
      chk("perf_flush", 32'(stall_cnt), 32'(SAT));
      cyc(1, 0, 0, 0, 0);
      chk("perf_rst", 32'(stall_cnt), 32'd0);
`endif

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(255) == 0), ($urandom_range(31) == 0),
             ($urandom_range(3) != 0), $urandom,
             ($urandom_range(2) != 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/skid_pipe_reg.md
SKID_PIPE_REG -- requirements
Module: skid_pipe_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data path width in bits (>=1).
REQ-002 SHALL have parameter RESET_VAL, default 0, WIDTH-bit value driven on out_data after reset/flush.
REQ-003 SHALL have parameter CNT_W, default 16, stall counter width (used only with SKID_PIPE_REG_PERF_EN).
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port flush  input  1  discard all held entries (branch redirect).
REQ-007 SHALL have port in_valid  input  1  upstream beat present.
REQ-008 SHALL have port in_ready  output  1  block accepts beat; registered, no comb path from out_ready.
REQ-009 SHALL have port in_data  input  WIDTH  upstream payload (e.g. PC or instruction).
REQ-010 SHALL have port out_valid  output  1  downstream beat present; registered.
REQ-011 SHALL have port out_ready  input  1  downstream accepts beat.
REQ-012 SHALL have port out_data  output  WIDTH  downstream payload; registered.
REQ-013 SHALL have port stall_cnt  output  CNT_W  stall cycle count; present only with SKID_PIPE_REG_PERF_EN.

Function
REQ-014 SHALL transfer upstream when in_valid && in_ready, downstream when out_valid && out_ready.
REQ-015 SHALL hold two entries: main (drives out_*) and skid; states EMPTY, FULL (main only), SKID (main+skid).
REQ-016 SHALL transition EMPTY->FULL on input transfer; no other exit from EMPTY except flush/reset (no-op).
REQ-017 SHALL in FULL: output-only ->EMPTY; input-only ->SKID (beat into skid); both ->FULL (beat into main); neither ->FULL.
REQ-018 SHALL in SKID: output transfer moves skid into main ->FULL; otherwise hold; in_ready=0 so no input accepted.
REQ-019 SHALL drive in_ready=1 in EMPTY and FULL, 0 in SKID.
REQ-020 SHALL present an accepted beat on out_valid/out_data one cycle after acceptance when main was empty or drained that cycle (latency 1).
REQ-021 SHALL sustain one transfer per cycle with out_ready held high; order preserved, no beat dropped or duplicated.
REQ-022 SHALL keep out_data stable while out_valid && !out_ready.
REQ-023 SHALL on flush: next cycle state EMPTY, out_valid=0, out_data=RESET_VAL, in_ready=1; a beat presented in the flush cycle is discarded; flush dominates all other events.
REQ-024 SHALL leave out_data at its last value when main drains without refill (only out_valid deasserts).

Reset
REQ-025 SHALL, while reset high, next edge force state EMPTY, out_valid=0, out_data=RESET_VAL, in_ready=1, stall_cnt=0.
REQ-026 SHALL give reset priority over flush and all handshakes; reset mid-transfer drops held beats.

Configuration
REQ-027 SHALL, with SKID_PIPE_REG_PERF_EN defined, expose stall_cnt: +1 each cycle out_valid && !out_ready, saturating at 2^CNT_W-1, cleared only by reset (not flush).
REQ-028 SHALL, without SKID_PIPE_REG_PERF_EN, omit stall_cnt port and counter logic entirely; all other behaviour identical.

Structure
REQ-029 SHALL place the state enum (EMPTY/FULL/SKID) and XLEN=32 constant in the shared package rv32i_pkg.
REQ-030 SHALL instantiate sub-module pipe_entry (WIDTH-bit register, sync reset to RESET_VAL, load enable) twice: main and skid.

Verification
REQ-031 SHALL cover streaming: out_ready=1, inputs 0x00000000..0x00000007 back-to-back -> same 8 values out, one per cycle, 1-cycle latency.
REQ-032 SHALL cover backpressure: out_ready=0 after 0xA, 0xB sent -> out_data=0xA held, in_ready=0 cycle after 0xB accepted; out_ready=1 -> 0xA then 0xB.
REQ-033 SHALL cover flush in SKID with in_valid=1, in_data=0xC -> next cycle out_valid=0, out_data=RESET_VAL, 0xC never emitted.
REQ-034 SHALL cover reset asserted with beat in flight, RESET_VAL=0x00001000 -> out_valid=0, out_data=0x00001000, in_ready=1.
REQ-035 SHALL cover PERF_EN, CNT_W=4: out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 (saturated); flush leaves 15; reset -> 0.
